// File: rtl/sdram_cmd_resp.sv
// Device-side SDR SDRAM command responder: decodes the command bus, tracks init/mode/bank state
// and command spacing, and flags protocol/timing violations. Optional: SDRAM_RESP_REFWDOG_EN.
module sdram_cmd_resp #(
  parameter int INIT_CYC = 20000,
  parameter int tRP      = 3,
  parameter int tRFC     = 7,
  parameter int tMRD     = 2,
  parameter int tRCD     = 3,
  parameter int REF_MIN  = 2,
  parameter int REF_MAX  = 782
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sdr_cke,
  input  logic        sdr_csn,
  input  logic        sdr_rasn,
  input  logic        sdr_casn,
  input  logic        sdr_wen,
  input  logic [10:0] sdr_addr,
  input  logic [1:0]  sdr_ba,
  output logic        cmd_valid,
  output logic [3:0]  cmd_code,
  output logic        init_ok,
  output logic [10:0] mode_reg,
  output logic [3:0]  bank_open,
  output logic [15:0] refresh_cnt,
  output logic        err_seq,
  output logic        err_timing,
  output logic        err_refresh,
  output logic        err_sticky,
  output logic [2:0]  first_err
);

  localparam int BUSY_MAX = (tRFC > tRP) ? ((tRFC > tMRD) ? tRFC : tMRD)
                                         : ((tRP > tMRD) ? tRP : tMRD);
  localparam int BUSY_W = $clog2(BUSY_MAX + 1);
  localparam int INIT_W = $clog2(INIT_CYC + 1);
  localparam int RCD_W  = $clog2(tRCD + 1);
  localparam int REFC_W = $clog2(REF_MIN + 1);

  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYC - 1);
  localparam logic [BUSY_W-1:0] RP_LOAD   = BUSY_W'(tRP - 1);
  localparam logic [BUSY_W-1:0] RFC_LOAD  = BUSY_W'(tRFC - 1);
  localparam logic [BUSY_W-1:0] MRD_LOAD  = BUSY_W'(tMRD - 1);
  localparam logic [RCD_W-1:0]  RCD_LOAD  = RCD_W'(tRCD - 1);
  localparam logic [REFC_W-1:0] REF_LAST  = REFC_W'(REF_MIN - 1);

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_DESEL = 4'b1111;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_PWR   = 3'd1;
  localparam logic [2:0] E_ORDER = 3'd2;
  localparam logic [2:0] E_BANK  = 3'd3;
  localparam logic [2:0] E_BUSY  = 3'd4;
  localparam logic [2:0] E_RCD   = 3'd5;
  localparam logic [2:0] E_REFWD = 3'd6;

  typedef enum logic [2:0] {
    ST_POWERUP  = 3'd0,
    ST_WAIT_PRE = 3'd1,
    ST_WAIT_REF = 3'd2,
    ST_WAIT_MRS = 3'd3,
    ST_READY    = 3'd4
  } state_t;

  logic [3:0]              cmd_q, cmd_d;
  logic [10:0]             addr_q, addr_d;
  logic [1:0]              ba_q, ba_d;
  state_t                  state_q, state_d;
  logic [INIT_W-1:0]       init_cnt_q, init_cnt_d;
  logic [REFC_W-1:0]       ref_seen_q, ref_seen_d;
  logic [BUSY_W-1:0]       busy_q, busy_d, busy_dec;
  logic [3:0][RCD_W-1:0]   rcd_q, rcd_d;
  logic [3:0]              bank_q, bank_d;
  logic [10:0]             mode_q, mode_d;
  logic [15:0]             refresh_q, refresh_d;
  logic                    init_ok_q, init_ok_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic [3:0]              cmd_code_q, cmd_code_d;
  logic                    err_seq_q, err_seq_d;
  logic                    err_timing_q, err_timing_d;
  logic                    err_refresh_q, err_refresh_d;
  logic                    err_sticky_q, err_sticky_d;
  logic [2:0]              first_err_q, first_err_d;

  logic       is_valid, is_act, is_rw, is_pre, is_ref, is_mrs;
  logic       seq_err, tim_err, wd_trip, any_err;
  logic [2:0] seq_code, tim_code, err_code;

  // A deselected clock-enable cycle looks exactly like DESEL to the rest of the logic.
  always_comb begin
    if (sdr_cke) begin
      cmd_d = {sdr_csn, sdr_rasn, sdr_casn, sdr_wen};
    end else begin
      cmd_d = CMD_DESEL;
    end
    addr_d = sdr_addr;
    ba_d   = sdr_ba;
  end

  always_comb begin
    is_valid = !cmd_q[3] && (cmd_q != CMD_NOP);
    is_act   = (cmd_q == CMD_ACT);
    is_rw    = (cmd_q == CMD_READ) || (cmd_q == CMD_WRITE);
    is_pre   = (cmd_q == CMD_PRE);
    is_ref   = (cmd_q == CMD_REF);
    is_mrs   = (cmd_q == CMD_MRS);
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ref_seen_d = ref_seen_q;
    init_ok_d  = init_ok_q;
    bank_d     = bank_q;
    mode_d     = mode_q;
    refresh_d  = refresh_q;
    seq_err    = 1'b0;
    seq_code   = E_NONE;
    tim_err    = 1'b0;
    tim_code   = E_NONE;
    if (busy_q != BUSY_W'(0)) begin
      busy_dec = busy_q - BUSY_W'(1);
    end else begin
      busy_dec = busy_q;
    end
    busy_d = busy_dec;
    for (int b = 0; b < 4; b++) begin
      if (rcd_q[b] != RCD_W'(0)) begin
        rcd_d[b] = rcd_q[b] - RCD_W'(1);
      end else begin
        rcd_d[b] = rcd_q[b];
      end
    end

    // Spacing checks are global; the offending command still takes effect below.
    if (is_valid && (busy_q != BUSY_W'(0))) begin
      tim_err  = 1'b1;
      tim_code = E_BUSY;
    end else if (is_rw && (rcd_q[ba_q] != RCD_W'(0))) begin
      tim_err  = 1'b1;
      tim_code = E_RCD;
    end else begin
      tim_err  = 1'b0;
    end

    if (state_q != ST_POWERUP) begin
      if (is_pre) begin
        busy_d = RP_LOAD;
      end else if (is_ref) begin
        busy_d = RFC_LOAD;
        if (refresh_q != 16'hFFFF) begin
          refresh_d = refresh_q + 16'd1;
        end else begin
          refresh_d = refresh_q;
        end
      end else if (is_mrs) begin
        busy_d = MRD_LOAD;
        mode_d = addr_q;
      end else begin
        busy_d = busy_dec;
      end
    end else begin
      busy_d = busy_dec;
    end

    case (state_q)
      ST_POWERUP: begin
        if (init_cnt_q == INIT_LAST) begin
          state_d = ST_WAIT_PRE;
        end else begin
          init_cnt_d = init_cnt_q + INIT_W'(1);
        end
        if (is_valid) begin
          seq_err  = 1'b1;
          seq_code = E_PWR;
        end else begin
          seq_err  = 1'b0;
        end
      end
      ST_WAIT_PRE: begin
        if (is_pre && addr_q[10]) begin
          state_d = ST_WAIT_REF;
        end else if (is_valid) begin
          seq_err  = 1'b1;
          seq_code = E_ORDER;
        end else begin
          state_d = ST_WAIT_PRE;
        end
      end
      ST_WAIT_REF: begin
        if (is_ref) begin
          if (ref_seen_q == REF_LAST) begin
            state_d = ST_WAIT_MRS;
          end else begin
            ref_seen_d = ref_seen_q + REFC_W'(1);
          end
        end else if (is_valid) begin
          seq_err  = 1'b1;
          seq_code = E_ORDER;
        end else begin
          state_d = ST_WAIT_REF;
        end
      end
      ST_WAIT_MRS: begin
        if (is_mrs) begin
          state_d   = ST_READY;
          init_ok_d = 1'b1;
        end else if (is_valid) begin
          seq_err  = 1'b1;
          seq_code = E_ORDER;
        end else begin
          state_d = ST_WAIT_MRS;
        end
      end
      ST_READY: begin
        if (is_act) begin
          if (bank_q[ba_q]) begin
            seq_err  = 1'b1;
            seq_code = E_BANK;
          end else begin
            seq_err  = 1'b0;
          end
          bank_d[ba_q] = 1'b1;
          rcd_d[ba_q]  = RCD_LOAD;
        end else if (is_rw) begin
          if (!bank_q[ba_q]) begin
            seq_err  = 1'b1;
            seq_code = E_BANK;
          end else begin
            seq_err  = 1'b0;
          end
        end else if (is_pre) begin
          if (addr_q[10]) begin
            bank_d = 4'b0000;
          end else begin
            bank_d[ba_q] = 1'b0;
          end
        end else if (is_ref || is_mrs) begin
          if (|bank_q) begin
            seq_err  = 1'b1;
            seq_code = E_BANK;
          end else begin
            seq_err  = 1'b0;
          end
        end else begin
          bank_d = bank_q;
        end
      end
      default: begin
        state_d = ST_POWERUP;
      end
    endcase
  end

`ifdef SDRAM_RESP_REFWDOG_EN
  localparam logic [15:0] REF_MAX_W = 16'(REF_MAX);
  logic [15:0] wdog_q, wdog_d;

  always_comb begin
    if ((state_q == ST_READY) && !is_ref) begin
      if (wdog_q != 16'hFFFF) begin
        wdog_d = wdog_q + 16'd1;
      end else begin
        wdog_d = wdog_q;
      end
    end else begin
      wdog_d = 16'h0000;
    end
    wd_trip       = (state_q == ST_READY) && (wdog_d > REF_MAX_W);
    err_refresh_d = err_refresh_q | wd_trip;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= 16'h0000;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic ref_max_unused;
  assign ref_max_unused = (REF_MAX > 0);
  assign wd_trip        = 1'b0;
  assign err_refresh_d  = 1'b0;
`endif

  // Sequence errors outrank timing errors when both hit the same command.
  always_comb begin
    any_err = seq_err | tim_err | wd_trip;
    if (seq_err) begin
      err_code = seq_code;
    end else if (tim_err) begin
      err_code = tim_code;
    end else if (wd_trip) begin
      err_code = E_REFWD;
    end else begin
      err_code = E_NONE;
    end
    if (!err_sticky_q && any_err) begin
      first_err_d = err_code;
    end else begin
      first_err_d = first_err_q;
    end
    err_sticky_d = err_sticky_q | any_err;
    err_seq_d    = seq_err;
    err_timing_d = tim_err;
    cmd_valid_d  = is_valid;
    if (is_valid) begin
      cmd_code_d = cmd_q;
    end else begin
      cmd_code_d = cmd_code_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q         <= CMD_DESEL;
      addr_q        <= 11'h000;
      ba_q          <= 2'd0;
      state_q       <= ST_POWERUP;
      init_cnt_q    <= {INIT_W{1'b0}};
      ref_seen_q    <= {REFC_W{1'b0}};
      busy_q        <= {BUSY_W{1'b0}};
      rcd_q         <= {(4 * RCD_W){1'b0}};
      bank_q        <= 4'b0000;
      mode_q        <= 11'h000;
      refresh_q     <= 16'h0000;
      init_ok_q     <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_code_q    <= 4'b0000;
      err_seq_q     <= 1'b0;
      err_timing_q  <= 1'b0;
      err_refresh_q <= 1'b0;
      err_sticky_q  <= 1'b0;
      first_err_q   <= 3'd0;
    end else begin
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      ba_q          <= ba_d;
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      ref_seen_q    <= ref_seen_d;
      busy_q        <= busy_d;
      rcd_q         <= rcd_d;
      bank_q        <= bank_d;
      mode_q        <= mode_d;
      refresh_q     <= refresh_d;
      init_ok_q     <= init_ok_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_code_q    <= cmd_code_d;
      err_seq_q     <= err_seq_d;
      err_timing_q  <= err_timing_d;
      err_refresh_q <= err_refresh_d;
      err_sticky_q  <= err_sticky_d;
      first_err_q   <= first_err_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_code    = cmd_code_q;
  assign init_ok     = init_ok_q;
  assign mode_reg    = mode_q;
  assign bank_open   = bank_q;
  assign refresh_cnt = refresh_q;
  assign err_seq     = err_seq_q;
  assign err_timing  = err_timing_q;
  assign err_refresh = err_refresh_q;
  assign err_sticky  = err_sticky_q;
  assign first_err   = first_err_q;

endmodule

// File: tb/tb_sdram_cmd_resp.sv
// Directed bench for sdram_cmd_resp: vector table for READY-state bank/timing rules plus
// hand-written init, reset and error-priority sequences.
`timescale 1ns/1ps
module tb_sdram_cmd_resp;

  localparam logic [3:0] C_NOP   = 4'b0111;
  localparam logic [3:0] C_ACT   = 4'b0011;
  localparam logic [3:0] C_READ  = 4'b0101;
  localparam logic [3:0] C_WRITE = 4'b0100;
  localparam logic [3:0] C_BST   = 4'b0110;
  localparam logic [3:0] C_PRE   = 4'b0010;
  localparam logic [3:0] C_REF   = 4'b0001;
  localparam logic [3:0] C_MRS   = 4'b0000;
  localparam logic [3:0] C_DESEL = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sdr_cke = 1'b1;
  logic        sdr_csn = 1'b0, sdr_rasn = 1'b1, sdr_casn = 1'b1, sdr_wen = 1'b1;
  logic [10:0] sdr_addr = 11'h000;
  logic [1:0]  sdr_ba = 2'd0;
  logic        cmd_valid, init_ok, err_seq, err_timing, err_refresh, err_sticky;
  logic [3:0]  cmd_code, bank_open;
  logic [10:0] mode_reg;
  logic [15:0] refresh_cnt;
  logic [2:0]  first_err;

  int checks = 0;
  int errors = 0;

  sdram_cmd_resp #(.INIT_CYC(20), .REF_MAX(50)) dut (
    .clk(clk), .rst_n(rst_n), .sdr_cke(sdr_cke),
    .sdr_csn(sdr_csn), .sdr_rasn(sdr_rasn), .sdr_casn(sdr_casn), .sdr_wen(sdr_wen),
    .sdr_addr(sdr_addr), .sdr_ba(sdr_ba),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .init_ok(init_ok), .mode_reg(mode_reg),
    .bank_open(bank_open), .refresh_cnt(refresh_cnt), .err_seq(err_seq),
    .err_timing(err_timing), .err_refresh(err_refresh), .err_sticky(err_sticky),
    .first_err(first_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cke;
    logic [3:0]  cmd;
    logic [10:0] addr;
    logic [1:0]  ba;
    logic        exp_valid;
    logic        exp_seq;
    logic        exp_tim;
    logic [3:0]  exp_bank;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {20'h00000, cmd_valid, cmd_code, init_ok, mode_reg, bank_open, refresh_cnt,
            err_seq, err_timing, err_refresh, err_sticky, first_err};
  endfunction

  // Drive one command for one clock; return #1 after the capturing edge.
  task automatic issue(input logic [3:0] c, input logic [10:0] a, input logic [1:0] b,
                       input logic k);
    {sdr_csn, sdr_rasn, sdr_casn, sdr_wen} = c;
    sdr_addr = a;
    sdr_ba   = b;
    sdr_cke  = k;
    @(posedge clk);
    #1;
  endtask

  task automatic nop(input int n);
    repeat (n) issue(C_NOP, 11'h000, 2'd0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {sdr_csn, sdr_rasn, sdr_casn, sdr_wen} = C_NOP;
    sdr_cke = 1'b1;
    #1;
    chk("reset_outputs_zero", all_outs(), 64'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Full init; optionally drops a REF into POWERUP slot pwr_ref_at and checks its error pulse.
  task automatic do_init(input int pwr_ref_at, input logic [10:0] mrs_val);
    for (int i = 1; i <= 20; i++) begin
      if (i == pwr_ref_at) issue(C_REF, 11'h000, 2'd0, 1'b1);
      else nop(1);
      if (pwr_ref_at != 0 && i == pwr_ref_at + 1) begin
        chk("pwr_err_seq", {63'h0, err_seq}, 64'h1);
        chk("pwr_first_err", {61'h0, first_err}, 64'h1);
        chk("pwr_cmd_code", {60'h0, cmd_code}, {60'h0, C_REF});
      end
      if (pwr_ref_at != 0 && i == pwr_ref_at + 2) begin
        chk("pwr_err_seq_pulse_end", {63'h0, err_seq}, 64'h0);
      end
    end
    issue(C_PRE, 11'h400, 2'd0, 1'b1);
    nop(3);
    issue(C_REF, 11'h000, 2'd0, 1'b1);
    nop(7);
    issue(C_REF, 11'h000, 2'd0, 1'b1);
    nop(7);
    issue(C_MRS, mrs_val, 2'd0, 1'b1);
    nop(1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, C_ACT,   11'h000, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0001};
    vecs[1]  = '{1'b1, C_NOP,   11'h000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0001};
    vecs[2]  = '{1'b1, C_NOP,   11'h000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0001};
    vecs[3]  = '{1'b1, C_READ,  11'h000, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0001};
    vecs[4]  = '{1'b1, C_ACT,   11'h000, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0101};
    vecs[5]  = '{1'b1, C_WRITE, 11'h000, 2'd2, 1'b1, 1'b0, 1'b1, 4'b0101};
    vecs[6]  = '{1'b1, C_ACT,   11'h000, 2'd2, 1'b1, 1'b1, 1'b0, 4'b0101};
    vecs[7]  = '{1'b1, C_WRITE, 11'h000, 2'd3, 1'b1, 1'b1, 1'b0, 4'b0101};
    vecs[8]  = '{1'b1, C_PRE,   11'h000, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0100};
    vecs[9]  = '{1'b1, C_ACT,   11'h000, 2'd1, 1'b1, 1'b0, 1'b1, 4'b0110};
    vecs[10] = '{1'b1, C_NOP,   11'h000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0110};
    vecs[11] = '{1'b1, C_NOP,   11'h000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0110};
    vecs[12] = '{1'b1, C_REF,   11'h000, 2'd0, 1'b1, 1'b1, 1'b0, 4'b0110};
    vecs[13] = '{1'b1, C_BST,   11'h000, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0110};
    vecs[14] = '{1'b1, C_PRE,   11'h400, 2'd0, 1'b1, 1'b0, 1'b1, 4'b0000};
    vecs[15] = '{1'b1, C_DESEL, 11'h000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[16] = '{1'b0, C_ACT,   11'h000, 2'd3, 1'b0, 1'b0, 1'b0, 4'b0000};

    // Clean init sequence.
    do_reset();
    do_init(0, 11'h032);
    chk("init_ok", {63'h0, init_ok}, 64'h1);
    chk("init_mode_reg", {53'h0, mode_reg}, 64'h032);
    chk("init_refresh_cnt", {48'h0, refresh_cnt}, 64'h2);
    chk("init_err_sticky", {63'h0, err_sticky}, 64'h0);
    chk("init_first_err", {61'h0, first_err}, 64'h0);

    // READY-state vector table; outputs lag the driven command by one cycle.
    for (int i = 0; i <= 17; i++) begin
      if (i < 17) issue(vecs[i].cmd, vecs[i].addr, vecs[i].ba, vecs[i].cke);
      else nop(1);
      if (i > 0) begin
        chk($sformatf("vec%0d_cmd_valid", i - 1), {63'h0, cmd_valid}, {63'h0, vecs[i-1].exp_valid});
        chk($sformatf("vec%0d_err_seq", i - 1), {63'h0, err_seq}, {63'h0, vecs[i-1].exp_seq});
        chk($sformatf("vec%0d_err_timing", i - 1), {63'h0, err_timing}, {63'h0, vecs[i-1].exp_tim});
        chk($sformatf("vec%0d_bank_open", i - 1), {60'h0, bank_open}, {60'h0, vecs[i-1].exp_bank});
        if (vecs[i-1].exp_valid)
          chk($sformatf("vec%0d_cmd_code", i - 1), {60'h0, cmd_code}, {60'h0, vecs[i-1].cmd});
      end
    end
    chk("table_refresh_cnt", {48'h0, refresh_cnt}, 64'h3);
    chk("table_first_err", {61'h0, first_err}, 64'h5);
    chk("table_err_sticky", {63'h0, err_sticky}, 64'h1);

    // REF spacing below tRFC, then MRS relatch in READY.
    do_reset();
    do_init(0, 11'h032);
    issue(C_REF, 11'h000, 2'd0, 1'b1);
    nop(1);
    chk("rfc_first_ref_timing", {63'h0, err_timing}, 64'h0);
    chk("rfc_first_ref_cnt", {48'h0, refresh_cnt}, 64'h3);
    nop(3);
    issue(C_REF, 11'h000, 2'd0, 1'b1);
    nop(1);
    chk("rfc_second_ref_timing", {63'h0, err_timing}, 64'h1);
    chk("rfc_first_err", {61'h0, first_err}, 64'h4);
    chk("rfc_second_ref_cnt", {48'h0, refresh_cnt}, 64'h4);
    nop(6);
    issue(C_MRS, 11'h123, 2'd0, 1'b1);
    nop(1);
    chk("ready_mrs_mode_reg", {53'h0, mode_reg}, 64'h123);
    chk("ready_mrs_err_seq", {63'h0, err_seq}, 64'h0);

    // Command during POWERUP: error, but the init counter keeps running.
    do_reset();
    do_init(5, 11'h032);
    chk("pwr_init_ok", {63'h0, init_ok}, 64'h1);
    chk("pwr_first_err_kept", {61'h0, first_err}, 64'h1);
    chk("pwr_refresh_cnt", {48'h0, refresh_cnt}, 64'h2);

    // READ to a closed bank.
    do_reset();
    do_init(0, 11'h032);
    issue(C_READ, 11'h000, 2'd2, 1'b1);
    nop(1);
    chk("closed_read_err_seq", {63'h0, err_seq}, 64'h1);
    chk("closed_read_err_timing", {63'h0, err_timing}, 64'h0);
    chk("closed_read_first_err", {61'h0, first_err}, 64'h3);

    // Sequence and timing violation on the same command.
    do_reset();
    do_init(0, 11'h032);
    issue(C_PRE, 11'h400, 2'd0, 1'b1);
    issue(C_READ, 11'h000, 2'd0, 1'b1);
    nop(1);
    chk("dual_err_seq", {63'h0, err_seq}, 64'h1);
    chk("dual_err_timing", {63'h0, err_timing}, 64'h1);
    chk("dual_first_err", {61'h0, first_err}, 64'h3);

    // ACT then READ same bank next cycle, then precharge-all.
    do_reset();
    do_init(0, 11'h032);
    issue(C_ACT, 11'h000, 2'd1, 1'b1);
    issue(C_READ, 11'h000, 2'd1, 1'b1);
    nop(1);
    chk("rcd_err_timing", {63'h0, err_timing}, 64'h1);
    chk("rcd_err_seq", {63'h0, err_seq}, 64'h0);
    chk("rcd_first_err", {61'h0, first_err}, 64'h5);
    chk("rcd_bank_open", {60'h0, bank_open}, 64'h2);
    issue(C_PRE, 11'h400, 2'd0, 1'b1);
    nop(1);
    chk("pre_all_bank_open", {60'h0, bank_open}, 64'h0);

    // PRE without A10 while waiting for precharge-all is an order error.
    do_reset();
    nop(20);
    issue(C_PRE, 11'h000, 2'd0, 1'b1);
    nop(1);
    chk("order_err_seq", {63'h0, err_seq}, 64'h1);
    chk("order_first_err", {61'h0, first_err}, 64'h2);
    chk("order_init_ok", {63'h0, init_ok}, 64'h0);

    // Refresh watchdog.
    do_reset();
    do_init(0, 11'h032);
    nop(40);
    chk("wdog_quiet_40", {63'h0, err_refresh}, 64'h0);
    nop(20);
`ifdef SDRAM_RESP_REFWDOG_EN
    chk("wdog_err_refresh", {63'h0, err_refresh}, 64'h1);
    chk("wdog_first_err", {61'h0, first_err}, 64'h6);
    chk("wdog_err_sticky", {63'h0, err_sticky}, 64'h1);
`else
    chk("wdog_err_refresh_off", {63'h0, err_refresh}, 64'h0);
    chk("wdog_err_sticky_off", {63'h0, err_sticky}, 64'h0);
`endif

    // Asynchronous reset in WAIT_REF, then a full init.
    do_reset();
    nop(20);
    issue(C_PRE, 11'h400, 2'd0, 1'b1);
    nop(3);
    issue(C_REF, 11'h000, 2'd0, 1'b1);
    nop(2);
    chk("midreset_pre_refresh_cnt", {48'h0, refresh_cnt}, 64'h1);
    do_reset();
    do_init(0, 11'h032);
    chk("midreset_init_ok", {63'h0, init_ok}, 64'h1);
    chk("midreset_refresh_cnt", {48'h0, refresh_cnt}, 64'h2);
    chk("midreset_err_sticky", {63'h0, err_sticky}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_cmd_resp.md
Name: sdram_cmd_resp

Overview:
Synthesizable SDRAM-side command responder/checker: sits at the device end of the SDRAM command bus and decodes CS#/RAS#/CAS#/WE#/BA/ADDR exactly as an SDR SDRAM would. Tracks the power-up/init sequence, mode register, per-bank open state and tRP/tRFC/tMRD/tRCD spacing. Flags protocol and timing violations. Used as an on-chip/bench responder for the controller's init and auto-refresh paths.

Parameters:
INIT_CYC, 20000, cycles of mandatory NOP/DESEL after reset (200 us at 100 MHz)
tRP, 3, PRE to next command, cycles
tRFC, 7, REF to next command, cycles
tMRD, 2, MRS to next command, cycles
tRCD, 3, ACT to READ/WRITE same bank, cycles
REF_MIN, 2, REF commands required during init
REF_MAX, 782, max cycles between REFs once ready (watchdog only)

Ports:
clk  in  1  system clock, 100 MHz; command bus sampled on rising edge
rst_n  in  1  asynchronous active-low reset
sdr_cke  in  1  clock enable; 0 = cycle treated as DESEL
sdr_csn, sdr_rasn, sdr_casn, sdr_wen  in  1 each  command lines
sdr_addr  in  11  address / A10 = all-banks for PRE
sdr_ba  in  2  bank address
cmd_valid  out  1  pulse: non-NOP/DESEL command decoded
cmd_code  out  4  {csn,rasn,casn,wen} of that command
init_ok  out  1  init sequence completed correctly
mode_reg  out  11  last MRS value
bank_open  out  4  per-bank active flags
refresh_cnt  out  16  REF count, saturates at 0xFFFF
err_seq  out  1  pulse: illegal command for current state
err_timing  out  1  pulse: command within a timing window
err_refresh  out  1  sticky watchdog flag (optional feature)
err_sticky  out  1  sticky OR of all errors
first_err  out  3  code of first error: 1 powerup-cmd, 2 order, 3 bank-state, 4 tRP/tRFC/tMRD, 5 tRCD, 6 refresh; 0 none

Behaviour:
- All outputs registered; command sampled at edge T, outputs reflect it after edge T+1 (1-cycle latency).
- Reset (async, any time, incl. mid-sequence): all outputs 0, state POWERUP, counters cleared.
- Decode: 1xxx DESEL, 0111 NOP, 0011 ACT, 0101 READ, 0100 WRITE, 0110 BST, 0010 PRE, 0001 REF, 0000 MRS.
- Init FSM: POWERUP -> (INIT_CYC cycles elapsed) WAIT_PRE -> (PRE with A10=1) WAIT_REF -> (REF_MIN REFs) WAIT_MRS -> (MRS) READY.
- POWERUP: any non-NOP/DESEL -> err_seq, code 1; counter keeps running.
- WAIT_* states: any command other than the expected one (NOP/DESEL excepted) -> err_seq, code 2; state unchanged. PRE with A10=0 in WAIT_PRE is an order error.
- init_ok set when entering READY; cleared only by reset.
- Global busy counter: loaded tRP-1 / tRFC-1 / tMRD-1 on PRE / REF / MRS; decrements to 0. Non-NOP command while busy!=0 -> err_timing, code 4; command still takes effect.
- Per-bank tRCD counter loaded tRCD-1 on ACT; READ/WRITE to that bank while nonzero -> err_timing, code 5.
- READY bank rules: ACT on open bank, READ/WRITE on closed bank, REF or MRS with any bank open -> err_seq, code 3. PRE A10=1 clears all bank_open; A10=0 clears bank sdr_ba. ACT sets bank_open[sdr_ba].
- MRS latches sdr_addr into mode_reg (also in READY). REF increments refresh_cnt in any post-POWERUP state.
- Simultaneous seq and timing violation on one command: both pulses; first_err takes seq code.
- first_err written only when err_sticky is 0.

Optional Feature:
SDRAM_RESP_REFWDOG_EN: when defined, a 16-bit counter runs in READY, cleared by each REF; exceeding REF_MAX sets err_refresh (sticky), err_sticky, first_err=6 if first. When undefined, counter absent, err_refresh tied 0.

Test Plan:
INIT_CYC=20, NOPs 20 cycles, PRE A10=1, 3 NOPs, REF, 7 NOPs, REF, 7 NOPs, MRS addr=0x032 -> init_ok=1, mode_reg=0x032, refresh_cnt=2, err_sticky=0.
REF at cycle 5 of POWERUP -> err_seq pulse 1 cycle later, first_err=1, state still POWERUP.
After init, REF then REF 5 cycles later (tRFC=7) -> err_timing pulse, first_err=4, refresh_cnt increments both times.
ACT ba=1, READ ba=1 next cycle -> err_timing, first_err=5; READ ba=2 -> err_seq code 3; PRE A10=1 -> bank_open=0.
With SDRAM_RESP_REFWDOG_EN, REF_MAX=50: no REF for 51 cycles in READY -> err_refresh=1; without macro err_refresh stays 0.
Assert rst_n low mid-WAIT_REF -> all outputs 0 immediately; full init after release succeeds.
